// File: rtl/adder_share_ctrl_pkg.sv
// Shared types and widths for the time-multiplexed 32-bit adder controller.
package adder_share_ctrl_pkg;

  localparam int OP_W  = 32;
  localparam int ADD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/adder_share_ctrl_cla.sv
// 16-bit carry-lookahead adder: four 4-bit groups joined by a group-level lookahead carry unit.
module CLA_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g, p;
  logic [16:0] c;
  logic [3:0]  gg, gp;
  logic [4:0]  gc;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    // NOTE: every variable gets a value before any conditional/loop use so no latch is inferred.
    gg = '0;
    gp = '0;
    c  = '0;
    for (int j = 0; j < 4; j++) begin
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1]) |
              (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end
    // Group carries are flattened so no carry ripples between groups.
    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & cin);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0]) |
            (gp[3] & gp[2] & gp[1] & gp[0] & cin);
    for (int j = 0; j < 4; j++) begin
      c[4*j] = gc[j];
      for (int k = 0; k < 3; k++)
        c[4*j+k+1] = g[4*j+k] | (p[4*j+k] & c[4*j+k]);
    end
    c[16] = gc[4];
  end

  assign sum  = p ^ c[15:0];
  assign cout = c[16];

endmodule

// File: rtl/adder_share_ctrl.sv
// Two-requester, round-robin front end that computes a 33-bit a+b+cin with one shared
// 16-bit adder over two cycles (low half, then high half).
module adder_share_ctrl
  import adder_share_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [OP_W-1:0] req_a0,
  input  logic [OP_W-1:0] req_b0,
  input  logic            req_cin0,
  input  logic [OP_W-1:0] req_a1,
  input  logic [OP_W-1:0] req_b1,
  input  logic            req_cin1,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            res_id,
  output logic [OP_W-1:0] res_sum,
  output logic            res_cout
);

  state_t             state;
  logic               ptr;
  logic [OP_W-1:0]    op_a, op_b;
  logic               op_cin, carry;
  logic [1:0]         grant;
  logic [ADD_W-1:0]   add_a, add_b, add_sum;
  logic               add_cin, add_cout;

  always_comb begin
    grant = 2'b00;
    if (!rst && state == IDLE) begin
      unique case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready = grant;

  // Outside LO/HI the adder output is unused, so the low-half selection is a don't-care there.
  assign add_a   = (state == HI) ? op_a[OP_W-1:ADD_W] : op_a[ADD_W-1:0];
  assign add_b   = (state == HI) ? op_b[OP_W-1:ADD_W] : op_b[ADD_W-1:0];
  assign add_cin = (state == HI) ? carry : op_cin;

  CLA_16bit u_cla (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      op_cin    <= 1'b0;
      carry     <= 1'b0;
      res_valid <= 1'b0;
      res_id    <= 1'b0;
      res_sum   <= '0;
      res_cout  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every read sees pre-edge values.
      unique case (state)
        IDLE: if (|grant) begin
          op_a   <= grant[1] ? req_a1   : req_a0;
          op_b   <= grant[1] ? req_b1   : req_b0;
          op_cin <= grant[1] ? req_cin1 : req_cin0;
          res_id <= grant[1];
          ptr    <= ~grant[1];
          state  <= LO;
        end
        LO: begin
          res_sum[ADD_W-1:0] <= add_sum;
          carry              <= add_cout;
          state              <= HI;
        end
        HI: begin
          res_sum[OP_W-1:ADD_W] <= add_sum;
          res_cout              <= add_cout;
          res_valid             <= 1'b1;
          state                 <= DONE;
        end
        DONE: if (res_ready) begin
          res_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Scoreboard bench: a negedge monitor models arbitration and arithmetic, queues expected
// results at accept time and compares them when the DUT transfers a result.
module tb_adder_share_ctrl;

  typedef struct packed {
    logic        id;
    logic [32:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [31:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic        req_cin0 = 1'b0, req_cin1 = 1'b0;
  logic        res_valid, res_ready = 1'b1, res_id, res_cout;
  logic [31:0] res_sum;

  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sb[$];
  logic m_ptr = 1'b0;
  logic m_idle = 1'b1;
  int   k = 0;
  int   cycle = 0;
  int   last_acc = -100;
  int   last_spacing = 0;
  logic held_valid = 1'b0;
  logic [33:0] held = '0;
  logic bp_rand = 1'b0;
  logic [1:0] acc;

  adder_share_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_cin0(req_cin0),
    .req_a1(req_a1), .req_b1(req_b1), .req_cin1(req_cin1),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_sum(res_sum), .res_cout(res_cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] rr_pick(input logic [1:0] v, input logic p);
    if (v == 2'b11) return p ? 2'b10 : 2'b01;
    return v;
  endfunction

  // Monitor / reference model
  always @(negedge clk) begin
    logic [1:0] eg;
    exp_t e;
    cycle++;
    if (rst) begin
      sb.delete();
      m_ptr = 1'b0; m_idle = 1'b1; k = 0; held_valid = 1'b0;
      check("ready_in_reset", {62'd0, req_ready}, 64'd0);
    end else if (m_idle) begin
      eg = rr_pick(req_valid, m_ptr);
      check("grant", {62'd0, req_ready}, {62'd0, eg});
      check("idle_res_valid", {63'd0, res_valid}, 64'd0);
      if (eg != 2'b00) begin
        e.id  = eg[1];
        e.val = eg[1] ? 33'(req_a1) + 33'(req_b1) + 33'(req_cin1)
                      : 33'(req_a0) + 33'(req_b0) + 33'(req_cin0);
        sb.push_back(e);
        m_ptr = ~eg[1];
        m_idle = 1'b0;
        k = 0;
        last_spacing = cycle - last_acc;
        last_acc = cycle;
      end
    end else begin
      k++;
      check("busy_ready", {62'd0, req_ready}, 64'd0);
      check("latency", {63'd0, res_valid}, {63'd0, (k >= 3)});
      if (res_valid) begin
        if (held_valid)
          check("hold_stable", {30'd0, res_id, res_cout, res_sum}, {30'd0, held});
        if (res_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_result", {63'd0, res_valid}, 64'd0);
          end else begin
            e = sb.pop_front();
            check("res_id", {63'd0, res_id}, {63'd0, e.id});
            check("res_val", {31'd0, res_cout, res_sum}, {31'd0, e.val});
          end
          m_idle = 1'b1;
          held_valid = 1'b0;
        end else begin
          held = {res_id, res_cout, res_sum};
          held_valid = 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (bp_rand) res_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic issue(input logic [1:0] mask,
                       input logic [31:0] a0, input logic [31:0] b0, input logic c0,
                       input logic [31:0] a1, input logic [31:0] b1, input logic c1);
    req_a0 = a0; req_b0 = b0; req_cin0 = c0;
    req_a1 = a1; req_b1 = b1; req_cin1 = c1;
    req_valid = mask;
    for (int i = 0; i < 60 && req_valid != 2'b00; i++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      req_valid = req_valid & ~acc;
    end
    if (req_valid != 2'b00) begin
      check("accept_timeout", {62'd0, req_valid}, 64'd0);
      req_valid = 2'b00;
    end
  endtask

  task automatic wait_res_valid();
    for (int i = 0; i < 20 && !res_valid; i++) begin
      @(posedge clk); #1;
    end
    if (!res_valid) check("res_valid_timeout", {63'd0, res_valid}, 64'd1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rc;
    repeat (2) @(posedge clk);
    #1;
    check("rst_res_valid", {63'd0, res_valid}, 64'd0);
    check("rst_res_sum", {32'd0, res_sum}, 64'd0);
    check("rst_res_cout", {63'd0, res_cout}, 64'd0);
    check("rst_res_id", {63'd0, res_id}, 64'd0);
    rst = 1'b0;

    // Only requester 0
    res_ready = 1'b1;
    issue(2'b01, 32'h0000FFFF, 32'h00000001, 1'b0, '0, '0, 1'b0);
    wait_res_valid();
    check("r0_sum", {32'd0, res_sum}, 64'h00010000);
    check("r0_cout", {63'd0, res_cout}, 64'd0);
    check("r0_id", {63'd0, res_id}, 64'd0);
    repeat (2) @(posedge clk);

    // Only requester 1, full carry chain
    #1;
    issue(2'b10, '0, '0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    wait_res_valid();
    check("r1_sum", {32'd0, res_sum}, 64'hFFFFFFFF);
    check("r1_cout", {63'd0, res_cout}, 64'd1);
    check("r1_id", {63'd0, res_id}, 64'd1);
    repeat (2) @(posedge clk);

    // Both valid straight after reset: req 0 first, accepts 4 cycles apart
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    issue(2'b11, 32'd1, 32'd2, 1'b0, 32'd10, 32'd20, 1'b1);
    check("rr_spacing", 64'(last_spacing), 64'd4);
    repeat (6) @(posedge clk);

    // Back-pressure in DONE with requests present (must be ignored)
    #1 res_ready = 1'b0;
    issue(2'b01, 32'h12345678, 32'h9ABCDEF0, 1'b1, '0, '0, 1'b0);
    wait_res_valid();
    req_valid = 2'b11;
    repeat (5) @(posedge clk);
    #1 req_valid = 2'b00;
    res_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_transfer", {63'd0, res_valid}, 64'd0);
    repeat (2) @(posedge clk);

    // Reset while in HI: no result, then req 0 wins arbitration
    #1;
    issue(2'b01, 32'h00000005, 32'h00000006, 1'b0, '0, '0, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    #1 check("rst_mid_valid", {63'd0, res_valid}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    issue(2'b11, 32'd7, 32'd8, 1'b1, 32'd100, 32'd200, 1'b0);
    repeat (6) @(posedge clk);

    // Randomised traffic alternating requesters under random back-pressure
    #1 bp_rand = 1'b1;
    for (int i = 0; i < 200; i++) begin
      ra = (i % 17 == 0) ? 32'hFFFFFFFF : $urandom;
      rb = (i % 13 == 0) ? 32'hFFFFFFFF : $urandom;
      rc = 1'($urandom_range(0, 1));
      if (i % 2 == 0) issue(2'b01, ra, rb, rc, '0, '0, 1'b0);
      else            issue(2'b10, '0, '0, 1'b0, ra, rb, rc);
    end
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
    bp_rand = 1'b0;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_share_ctrl.md
ADDER_SHARE_CTRL -- requirements
Module: adder_share_ctrl

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 32 bits, adder width at 16 bits, requester count at 2.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  2  per-requester request valid (bit i = requester i).
REQ-005 req_ready  output  2  per-requester accept; request i is accepted in a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-006 req_a0, req_b0  input  32 each  requester 0 operands; req_cin0  input  1  requester 0 carry-in.
REQ-007 req_a1, req_b1  input  32 each  requester 1 operands; req_cin1  input  1  requester 1 carry-in.
REQ-008 res_valid  output  1  result valid.
REQ-009 res_ready  input  1  result consumer ready; result transfers when res_valid and res_ready are both 1.
REQ-010 res_id  output  1  index of the requester that owns the result.
REQ-011 res_sum  output  32  result sum; res_cout  output  1  result carry-out.

Function
REQ-012 The block SHALL compute {res_cout,res_sum} = a + b + cin (33-bit, exact) using one shared 16-bit adder over two cycles.
REQ-013 FSM states SHALL be IDLE, LO, HI, DONE.
REQ-014 IDLE: req_ready SHALL be the one-hot grant; with no req_valid bits set, req_ready = 0 and the FSM stays in IDLE.
REQ-015 Arbitration SHALL be round-robin: with one valid, grant it; with both valid, grant the requester indicated by the priority pointer; after each grant the pointer SHALL move to the other requester.
REQ-016 On accept, the block SHALL register operands, cin and the grant index, and go to LO.
REQ-017 LO: the adder SHALL add a[15:0] + b[15:0] + cin; sum to result[15:0], carry to an internal carry register; next state HI.
REQ-018 HI: the adder SHALL add a[31:16] + b[31:16] + internal carry; sum to result[31:16], carry to res_cout; next state DONE.
REQ-019 DONE: res_valid = 1; res_sum, res_cout and res_id SHALL remain stable until transfer; on transfer go to IDLE.
REQ-020 req_ready SHALL be 0 in LO, HI and DONE; req_valid in those states SHALL be ignored and needs no holding.
REQ-021 Latency: res_valid SHALL rise on the 3rd rising edge after the accept edge; minimum accept-to-accept spacing is 4 cycles.
REQ-022 res_valid, res_sum, res_cout and res_id SHALL be registered outputs; req_ready MAY be combinational from state, pointer and req_valid.
REQ-023 The shared adder SHALL be idle (inputs don't-care) in IDLE and DONE.

Reset
REQ-024 On rst: state = IDLE, res_valid = 0, res_sum = 0, res_cout = 0, res_id = 0, internal carry = 0, priority pointer = requester 0.
REQ-025 Reset asserted mid-operation (LO, HI, DONE) SHALL discard the in-flight request without producing a result.
REQ-026 req_ready SHALL be 0 while rst is high.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (IDLE=0, LO=1, HI=2, DONE=3) and constants OP_W=32, ADD_W=16.
REQ-028 The block SHALL contain exactly one instance of the team's 16-bit carry-lookahead adder, CLA_16bit (a, b, cin, sum, cout), as its only sub-module.

Verification
REQ-029 Only req 0 valid: a=0x0000FFFF, b=0x00000001, cin=0 -> after 3 edges res_valid=1, res_id=0, res_sum=0x00010000, res_cout=0.
REQ-030 Only req 1 valid: a=0xFFFFFFFF, b=0xFFFFFFFF, cin=1 -> res_id=1, res_sum=0xFFFFFFFF, res_cout=1.
REQ-031 Both valid after reset, res_ready=1, req 0: 1+2+0, req 1: 10+20+1 -> first result res_id=0 sum=3, second res_id=1 sum=31, accepts 4 cycles apart.
REQ-032 res_ready held 0 for 5 cycles in DONE -> res_valid, res_sum, res_id stable, req_ready=2'b00 throughout; transfer on first res_ready=1.
REQ-033 rst asserted in HI -> res_valid=0 immediately; after release with both valid, req 0 granted first.
REQ-034 Random self-check: 200 random operand pairs alternated across requesters -> every {res_cout,res_sum} equals a+b+cin, res_id matches issuing requester.
